// File: rtl/mul256_operand_sequencer.sv
// Operand sequencer for the 256x256 sequential multiplier.
// Collects operand A and then operand B from a narrow word stream. Raises the multiplier start
// level and keeps A/B frozen while the multiplier runs. Catches the product on the falling edge
// of busy and presents it downstream on a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_in_valid/o_in_ready/i_in_data   word stream: A words then B words, LS word first
//   o_mul_start         multiplier start level (low holds the multiplier in Init)
//   i_mul_busy          multiplier busy
//   o_mul_a/o_mul_b     registered operands
//   i_mul_c             multiplier product
//   o_res_valid/i_res_ready/o_res_data   captured product handshake
//   o_err_timeout       sticky: busy never rose after start
module mul256_operand_sequencer #(
   parameter int unsigned WORD_W  = 64,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_in_data,
   output logic              o_mul_start,
   input  logic              i_mul_busy,
   output logic [255:0]      o_mul_a,
   output logic [255:0]      o_mul_b,
   input  logic [511:0]      i_mul_c,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [511:0]      o_res_data,
   output logic              o_err_timeout
);

   localparam int unsigned NW     = 256 / WORD_W;
   localparam int unsigned CNT_W  = $clog2(2 * NW);
   localparam int unsigned WAIT_W = $clog2(TIMEOUT);

   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(2 * NW - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic [1:0]        r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic [WAIT_W-1:0] r_wait, w_wait_d;
   logic              r_start, w_start_d;
   logic              r_res_valid, w_res_valid_d;
   logic              r_err, w_err_d;
   logic [255:0]      r_mul_a, r_mul_b;
   logic [511:0]      r_res_data;
   logic              w_xfer;
   logic              w_capture;

   // Ready depends on state alone so upstream never sees a combinational path from valid.
   assign o_in_ready = (r_state == ST_LOAD);
   assign w_xfer     = i_in_valid & o_in_ready;

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_wait_d      = r_wait;
      w_start_d     = r_start;
      w_res_valid_d = r_res_valid;
      w_err_d       = r_err;
      w_capture     = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_start_d = 1'b0;
            if (w_xfer) begin
               if (r_cnt == LAST_WORD) begin
                  w_cnt_d   = '0;
                  w_wait_d  = '0;
                  w_start_d = 1'b1;
                  w_state_d = ST_ARM;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
         end
         ST_ARM: begin
            if (i_mul_busy) begin
               w_state_d = ST_RUN;
            end else if (r_wait == WAIT_LAST) begin
               // Multiplier never started: drop the operation and accept the next one.
               w_err_d   = 1'b1;
               w_start_d = 1'b0;
               w_state_d = ST_LOAD;
            end else begin
               w_wait_d = r_wait + 1'b1;
            end
         end
         ST_RUN: begin
            if (!i_mul_busy) begin
               w_capture     = 1'b1;
               w_res_valid_d = 1'b1;
               w_start_d     = 1'b0;
               w_state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_start_d = 1'b0;
            if (i_res_ready) begin
               w_res_valid_d = 1'b0;
               w_state_d     = ST_LOAD;
            end
         end
         default: begin
            w_start_d     = 1'b0;
            w_res_valid_d = 1'b0;
            w_state_d     = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_LOAD;
         r_cnt       <= '0;
         r_wait      <= '0;
         r_start     <= 1'b0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_wait      <= w_wait_d;
         r_start     <= w_start_d;
         r_res_valid <= w_res_valid_d;
         r_err       <= w_err_d;
      end
   end

   // Operand words land at fixed slots; transfers only happen in LOAD, so A/B stay frozen
   // from the start rise until the product is handed off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_res_data <= '0;
      end else begin
         for (int k = 0; k < NW; k++) begin
            if (w_xfer && (r_cnt == CNT_W'(k))) begin
               r_mul_a[k*WORD_W +: WORD_W] <= i_in_data;
            end
            if (w_xfer && (r_cnt == CNT_W'(NW + k))) begin
               r_mul_b[k*WORD_W +: WORD_W] <= i_in_data;
            end
         end
         if (w_capture) begin
            r_res_data <= i_mul_c;
         end
      end
   end

   assign o_mul_start   = r_start;
   assign o_mul_a       = r_mul_a;
   assign o_mul_b       = r_mul_b;
   assign o_res_valid   = r_res_valid;
   assign o_res_data    = r_res_data;
   assign o_err_timeout = r_err;

endmodule

// File: tb/tb_mul256_operand_sequencer.sv
// Testbench for mul256_operand_sequencer: random and directed operations, a behavioural
// multiplier model, and a scoreboard queue of expected products popped by a monitor.
module tb_mul256_operand_sequencer;

   localparam int unsigned WORD_W  = 64;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned NW      = 256 / WORD_W;

   logic              clk;
   logic              rst_n;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [WORD_W-1:0] i_in_data;
   logic              o_mul_start;
   logic              mul_busy;
   logic [255:0]      o_mul_a;
   logic [255:0]      o_mul_b;
   logic [511:0]      mul_c;
   logic              o_res_valid;
   logic              i_res_ready;
   logic [511:0]      o_res_data;
   logic              o_err_timeout;

   int checks   = 0;
   int failures = 0;
   logic [511:0] exp_q[$];
   logic         stuck;

   mul256_operand_sequencer #(
      .WORD_W (WORD_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_data    (i_in_data),
      .o_mul_start  (o_mul_start),
      .i_mul_busy   (mul_busy),
      .o_mul_a      (o_mul_a),
      .o_mul_b      (o_mul_b),
      .i_mul_c      (mul_c),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res_data   (o_res_data),
      .o_err_timeout(o_err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: busy high from 1 to 5 cycles after start rose, product valid afterwards.
   logic [2:0]   mc;
   logic [511:0] prod;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            mc <= 3'd0;
      else if (!o_mul_start) mc <= 3'd0;
      else if (mc != 3'd7)   mc <= mc + 3'd1;
   end
   assign mul_busy = !stuck && o_mul_start && (mc >= 3'd1) && (mc <= 3'd5);
   assign prod     = {256'b0, o_mul_a} * {256'b0, o_mul_b};
   assign mul_c    = (mc >= 3'd6) ? prod : ~prod;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each result handshake and watches hold-state invariants.
   logic         pv, phs, ps;
   logic [511:0] pd, pab;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
         phs = 1'b0;
         ps = 1'b0;
      end else begin
         if (o_res_valid) begin
            chk("hold_ctl", {510'b0, o_mul_start, o_in_ready}, 512'b0);
            if (pv && !phs) chk("res_stable", o_res_data, pd);
         end
         if (o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got %h want none", o_res_data);
            end else begin
               chk("product", o_res_data, exp_q.pop_front());
            end
         end
         if (ps && o_mul_start) chk("ab_stable", {o_mul_a, o_mul_b}, pab);
         pv  = o_res_valid;
         phs = o_res_valid && i_res_ready;
         pd  = o_res_data;
         ps  = o_mul_start;
         pab = {o_mul_a, o_mul_b};
      end
   end

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send_word(input logic [WORD_W-1:0] w, input int max_gap);
      int   g;
      logic rdy;
      logic done;
      g = $urandom_range(0, max_gap);
      done = 1'b0;
      i_in_valid = 1'b0;
      repeat (g) begin
         @(posedge clk);
         #1;
      end
      i_in_valid = 1'b1;
      i_in_data  = w;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         rdy = o_in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1'b1;
            break;
         end
      end
      i_in_valid = 1'b0;
      i_in_data  = $urandom;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL in_handshake: got no ready want ready within 200 cycles");
      end
   endtask

   task automatic send_op(input logic [255:0] a, input logic [255:0] b, input int max_gap,
                          input logic push, input logic [511:0] exp);
      if (push) exp_q.push_back(exp);
      for (int k = 0; k < 2 * NW; k++) begin
         if (k < NW) send_word(a[k*WORD_W +: WORD_W], max_gap);
         else        send_word(b[(k-NW)*WORD_W +: WORD_W], max_gap);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_res_valid();
      int t;
      for (t = 0; t < 200 && !o_res_valid; t++) begin
         @(posedge clk);
         #1;
      end
      chk("res_valid_wait", {511'b0, o_res_valid}, 512'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   logic [255:0] a, b, ones;
   initial begin
      rst_n       = 1'b0;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      i_res_ready = 1'b0;
      stuck       = 1'b0;
      ones        = '1;
      #1;
      chk("rst_start", {511'b0, o_mul_start}, 512'd0);
      chk("rst_ab", {o_mul_a, o_mul_b}, 512'd0);
      chk("rst_valid", {511'b0, o_res_valid}, 512'd0);
      chk("rst_data", o_res_data, 512'd0);
      chk("rst_err", {511'b0, o_err_timeout}, 512'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_rst", {511'b0, o_in_ready}, 512'd1);

      // A=1, B=1
      i_res_ready = 1'b1;
      send_op(256'd1, 256'd1, 0, 1'b1, 512'd1);
      drain();
      chk("err_clear", {511'b0, o_err_timeout}, 512'd0);

      // All ones squared
      send_op(ones, ones, 1, 1'b1, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
      drain();

      // Downstream stall with gapped input
      i_res_ready = 1'b0;
      a = rand256();
      b = rand256();
      send_op(a, b, 3, 1'b1, {256'b0, a} * {256'b0, b});
      wait_res_valid();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("stall_valid", {511'b0, o_res_valid}, 512'd1);
      chk("stall_rdy", {511'b0, o_in_ready}, 512'd0);
      i_res_ready = 1'b1;
      drain();
      a = rand256();
      b = rand256();
      send_op(a, b, 2, 1'b1, {256'b0, a} * {256'b0, b});
      drain();

      // Busy stuck low -> timeout
      stuck = 1'b1;
      send_op(rand256(), rand256(), 0, 1'b0, 512'd0);
      chk("arm_start", {510'b0, o_mul_start, o_err_timeout}, 512'd2);
      repeat (TIMEOUT - 1) begin
         @(posedge clk);
         #1;
      end
      chk("arm_wait", {510'b0, o_err_timeout, o_in_ready}, 512'd0);
      @(posedge clk);
      #1;
      chk("timeout", {509'b0, o_err_timeout, o_mul_start, o_in_ready}, 512'd5);
      stuck = 1'b0;
      send_op(256'd7, 256'd9, 0, 1'b1, 512'd63);
      drain();
      chk("err_sticky", {511'b0, o_err_timeout}, 512'd1);

      // Reset during RUN
      a = rand256();
      b = rand256();
      send_op(a, b, 0, 1'b1, {256'b0, a} * {256'b0, b});
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_run_ctl", {509'b0, o_mul_start, o_res_valid, o_err_timeout}, 512'd0);
      chk("rst_run_ab", {o_mul_a, o_mul_b}, 512'd0);
      exp_q.delete();
      #2;
      rst_n = 1'b1;
      a = rand256();
      b = rand256();
      send_op(a, b, 1, 1'b1, {256'b0, a} * {256'b0, b});
      drain();

      // Back-to-back
      a = '0;
      a[255] = 1'b1;
      send_op(256'd3, 256'd5, 0, 1'b1, 512'd15);
      send_op(a, 256'd2, 0, 1'b1, {255'b0, 1'b1, 256'b0});
      drain();

      // Random ops with random gaps and downstream delays
      for (int n = 0; n < 8; n++) begin
         a = rand256();
         b = (n == 3) ? 256'd0 : rand256();
         i_res_ready = 1'($urandom_range(0, 1));
         send_op(a, b, 2, 1'b1, {256'b0, a} * {256'b0, b});
         if (!i_res_ready) begin
            wait_res_valid();
            repeat ($urandom_range(0, 4)) begin
               @(posedge clk);
               #1;
            end
            i_res_ready = 1'b1;
         end
         drain();
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
